// File: rtl/arctic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arctic_pkg
// Description : Shared types and constants for the arctic step controller.
//               Defines the controller state encoding, the Galois LFSR
//               polynomial and default seed, and a single-step LFSR helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arctic_pkg;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // The ST_ prefix keeps the names clear of the SETTLE parameter.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_STEP   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One right-shift Galois step; the bit shifted out selects the feedback.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arctic_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : arctic_lfsr
// Description : 16-bit right-shift Galois LFSR (mask 0xB400).
//               A zero seed would lock the register at zero, so it is
//               replaced by the default seed on load.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               load, seed   - load seed (takes priority over advance)
//               advance      - advance one step
//               bit_out      - current lfsr[0], the bit about to shift out
// Revision    : 1.0 - initial release
// ============================================================================
module arctic_lfsr
    import arctic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic        bit_out
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED_DEFAULT;
        end else if (load) begin
            r_lfsr <= (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
        end else if (advance) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign bit_out = r_lfsr[0];

endmodule
`default_nettype wire

// File: rtl/arctic_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arctic_step_ctrl
// Description : Generation-step controller for a node array. Each step
//               shifts NODES fresh LFSR bits into rnd (FILL), holds them
//               stable for SETTLE cycles, then pulses step_en (STEP).
//               ORDER_MAX steps make a run, ending with a done pulse.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               start, abort        - begin / cancel a run
//               seed_valid, seed    - seed offer; seed_ready accepts (IDLE)
//               rnd[NODES-1:0]      - random bits for the node array
//               step_en             - node array update pulse
//               order[3:0]          - completed steps of the current run
//               busy, done          - run in progress / completion pulse
//               step_count[15:0]    - saturating step_en count since reset
//                                     (only with ARCTIC_STEP_COUNT_EN)
// Options     : `define ARCTIC_STEP_COUNT_EN adds the step_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module arctic_step_ctrl
    import arctic_pkg::*;
#(
    parameter int NODES     = 16,
    parameter int ORDER_MAX = 8,
    parameter int SETTLE    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_valid,
    input  logic [15:0]      seed,
    output logic             seed_ready,
    output logic [NODES-1:0] rnd,
    output logic             step_en,
    output logic [3:0]       order,
    output logic             busy,
    output logic             done
`ifdef ARCTIC_STEP_COUNT_EN
    ,
    output logic [15:0]      step_count
`endif
);

    localparam logic [6:0] c_fill_last   = 7'(NODES - 1);
    localparam logic [6:0] c_settle_last = 7'(SETTLE - 1);
    localparam logic [3:0] c_order_max   = 4'(ORDER_MAX);

    state_t           r_state;
    state_t           w_state_next;
    logic [6:0]       r_cnt;
    logic [NODES-1:0] r_rnd;
    logic [NODES-1:0] w_rnd_shift;
    logic [3:0]       r_order;
    logic [3:0]       w_order_inc;
    logic             r_busy;
    logic             r_done;
    logic             r_seed_ready;
    logic             w_load;
    logic             w_advance;
    logic             w_step;
    logic             w_lfsr_bit;

    assign w_load      = seed_valid && r_seed_ready;
    // An abort freezes rnd, order and the LFSR in the cycle it is seen.
    assign w_advance   = (r_state == ST_FILL) && !abort;
    // step_en is gated by abort directly so an abort seen during STEP
    // suppresses the pulse in that same cycle.
    assign w_step      = (r_state == ST_STEP) && !abort;
    assign w_order_inc = r_order + 4'd1;

    arctic_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .seed    (seed),
        .advance (w_advance),
        .bit_out (w_lfsr_bit)
    );

    generate
        if (NODES == 1) begin : g_rnd_single
            assign w_rnd_shift = w_lfsr_bit;
        end else begin : g_rnd_multi
            assign w_rnd_shift = {r_rnd[NODES-2:0], w_lfsr_bit};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_FILL;
            ST_FILL: begin
                if (abort)                     w_state_next = ST_IDLE;
                else if (r_cnt == c_fill_last) w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort)                       w_state_next = ST_IDLE;
                else if (r_cnt == c_settle_last) w_state_next = ST_STEP;
            end
            ST_STEP: begin
                if (abort)                            w_state_next = ST_IDLE;
                else if (w_order_inc == c_order_max)  w_state_next = ST_DONE;
                else                                  w_state_next = ST_FILL;
            end
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 7'd0;
            r_rnd        <= '0;
            r_order      <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_seed_ready <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_busy       <= (w_state_next == ST_FILL) || (w_state_next == ST_SETTLE) ||
                            (w_state_next == ST_STEP);
            r_done       <= (w_state_next == ST_DONE);
            r_seed_ready <= (w_state_next == ST_IDLE);

            // Shared phase counter for FILL and SETTLE, restarted on entry.
            if (w_state_next != r_state) begin
                r_cnt <= 7'd0;
            end else if ((r_state == ST_FILL) || (r_state == ST_SETTLE)) begin
                r_cnt <= r_cnt + 7'd1;
            end

            if ((r_state == ST_IDLE) && start) begin
                r_order <= 4'd0;
            end else if (w_step) begin
                r_order <= w_order_inc;
            end

            if (w_advance) begin
                r_rnd <= w_rnd_shift;
            end
        end
    end

    assign seed_ready = r_seed_ready;
    assign rnd        = r_rnd;
    assign step_en    = w_step;
    assign order      = r_order;
    assign busy       = r_busy;
    assign done       = r_done;

`ifdef ARCTIC_STEP_COUNT_EN
    logic [15:0] r_step_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_count <= 16'd0;
        end else if (w_step && (r_step_count != 16'hFFFF)) begin
            r_step_count <= r_step_count + 16'd1;
        end
    end

    assign step_count = r_step_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arctic_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arctic_step_ctrl
// Description : Self-checking bench for arctic_step_ctrl. Expected step_en /
//               done events (edge number, rnd, order) are queued when a run
//               is started and compared when the DUT emits them. A second
//               instance with NODES=6 checks the first fill pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arctic_step_ctrl;

    typedef struct {
        int          kind;     // 0 = step_en, 1 = done
        int          at_edge;  // clock edge that samples the pulse
        logic [15:0] rnd;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        seed_valid;
    logic [15:0] seed;
    logic        seed_ready;
    logic [15:0] rnd;
    logic        step_en;
    logic [3:0]  order;
    logic        busy;
    logic        done;

    logic        start6;
    logic        seed_ready6;
    logic [5:0]  rnd6;
    logic        step_en6;
    logic [3:0]  order6;
    logic        busy6;
    logic        done6;

`ifdef ARCTIC_STEP_COUNT_EN
    logic [15:0] step_count;
    logic [15:0] step_count6;
`endif

    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;
    ev_t         q[$];
    logic [15:0] m_lfsr;
    logic [15:0] m_rnd;

    arctic_step_ctrl dut (
`ifdef ARCTIC_STEP_COUNT_EN
        .step_count (step_count),
`endif
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready),
        .rnd        (rnd),
        .step_en    (step_en),
        .order      (order),
        .busy       (busy),
        .done       (done)
    );

    arctic_step_ctrl #(.NODES(6), .ORDER_MAX(1), .SETTLE(2)) dut6 (
`ifdef ARCTIC_STEP_COUNT_EN
        .step_count (step_count6),
`endif
        .clk        (clk),
        .rst        (rst),
        .start      (start6),
        .abort      (1'b0),
        .seed_valid (1'b0),
        .seed       (16'h0000),
        .seed_ready (seed_ready6),
        .rnd        (rnd6),
        .step_en    (step_en6),
        .order      (order6),
        .busy       (busy6),
        .done       (done6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] galois(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic model_fill(input int n);
        for (int i = 0; i < n; i++) begin
            m_rnd  = {m_rnd[14:0], m_lfsr[0]};
            m_lfsr = galois(m_lfsr);
        end
    endtask

    task automatic push_ev(input int kind, input int at_edge, input logic [15:0] r);
        ev_t e;
        e.kind    = kind;
        e.at_edge = at_edge;
        e.rnd     = r;
        q.push_back(e);
    endtask

    // Full default run started at edge k: 16 fill + 2 settle + 1 step per order.
    task automatic plan_run(input int k);
        for (int i = 1; i <= 8; i++) begin
            model_fill(16);
            push_ev(0, k + 19 * i, m_rnd);
        end
        push_ev(1, k + 153, 16'h0000);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while ((q.size() != 0) && (n < budget)) begin
            tick(1);
            n++;
        end
        chk("sb_drain", q.size(), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rnd"},        rnd,        16'h0000);
        chk({tag, "_order"},      order,      4'd0);
        chk({tag, "_busy"},       busy,       1'b0);
        chk({tag, "_done"},       done,       1'b0);
        chk({tag, "_step_en"},    step_en,    1'b0);
        chk({tag, "_seed_ready"}, seed_ready, 1'b1);
    endtask

    // Scoreboard consumer: events are sampled on the falling edge and
    // tagged with the rising edge that will sample them.
    ev_t e_mon;
    always @(negedge clk) begin
        if (!rst && (step_en || done)) begin
            if (q.size() == 0) begin
                chk("sb_unexpected", {step_en, done}, 2'b00);
            end else begin
                e_mon = q.pop_front();
                chk("ev_kind", {31'd0, done}, e_mon.kind);
                chk("ev_edge", cyc + 1, e_mon.at_edge);
                if (e_mon.kind == 0) chk("step_rnd", rnd, e_mon.rnd);
                else                 chk("done_order", order, 4'd8);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst        = 1'b1;
        start      = 1'b0;
        start6     = 1'b0;
        abort      = 1'b0;
        seed_valid = 1'b0;
        seed       = 16'h0000;
        m_lfsr     = 16'hACE1;
        m_rnd      = 16'h0000;

        tick(3);
        chk_reset_state("rst_hold");
        chk("rst_rnd6", rnd6, 6'd0);
        rst = 1'b0;
        tick(2);
        chk_reset_state("rst_rel");

        // NODES=6 instance: first fill from the default seed.
        k = cyc + 1;
        start6 = 1'b1;
        tick(1);
        start6 = 1'b0;
        wait_cyc(k + 6);
        chk("n6_rnd_settle", rnd6, 6'b100001);
        chk("n6_busy", busy6, 1'b1);
        chk("n6_step_low", step_en6, 1'b0);
        wait_cyc(k + 8);
        chk("n6_step", step_en6, 1'b1);
        wait_cyc(k + 9);
        chk("n6_done", done6, 1'b1);
        chk("n6_order", order6, 4'd1);

        // Run A: default seed, with a stray start during SETTLE.
        tick(2);
        k = cyc + 1;
        start = 1'b1;
        plan_run(k);
        chk("a_busy_before", busy, 1'b0);
        tick(1);
        start = 1'b0;
        chk("a_busy_first", busy, 1'b1);
        chk("a_seed_ready", seed_ready, 1'b0);
        chk("a_order_clr", order, 4'd0);
        wait_cyc(k + 16);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_cyc(k + 151);
        chk("a_busy_last", busy, 1'b1);
        wait_cyc(k + 152);
        chk("a_busy_off", busy, 1'b0);
        chk("a_done", done, 1'b1);
        wait_cyc(k + 153);
        chk("a_done_off", done, 1'b0);
        chk("a_order", order, 4'd8);
        chk("a_seed_ready_idle", seed_ready, 1'b1);
        wait_empty(20);

        // Run B: zero seed loaded together with start behaves as 0xACE1.
        tick(2);
        chk("b_seed_ready", seed_ready, 1'b1);
        seed_valid = 1'b1;
        seed       = 16'h0000;
        start      = 1'b1;
        m_lfsr     = 16'hACE1;
        plan_run(cyc + 1);
        tick(1);
        seed_valid = 1'b0;
        start      = 1'b0;
        wait_empty(300);
        chk("b_order", order, 4'd8);
`ifdef ARCTIC_STEP_COUNT_EN
        chk("step_count_two_runs", step_count, 16'd16);
`endif

        // Abort on the 5th FILL cycle of the second step.
        tick(2);
        seed_valid = 1'b1;
        seed       = 16'h1234;
        tick(1);
        seed_valid = 1'b0;
        m_lfsr     = 16'h1234;
        k = cyc + 1;
        start = 1'b1;
        model_fill(16);
        push_ev(0, k + 19, m_rnd);
        model_fill(4);
        tick(1);
        start = 1'b0;
        wait_cyc(k + 23);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("ab_busy", busy, 1'b0);
        chk("ab_idle", seed_ready, 1'b1);
        chk("ab_rnd", rnd, m_rnd);
        chk("ab_order", order, 4'd1);
        tick(5);
        chk("ab_rnd_hold", rnd, m_rnd);
        chk("ab_order_hold", order, 4'd1);
        chk("ab_no_step", q.size(), 0);

        // Run C continues from the LFSR state frozen by the abort.
        start = 1'b1;
        plan_run(cyc + 1);
        tick(1);
        start = 1'b0;
        wait_empty(300);

        // Reset during SETTLE abandons the run.
        tick(2);
        k = cyc + 1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_cyc(k + 17);
        rst = 1'b1;
        tick(2);
        chk_reset_state("mid_rst");
        rst    = 1'b0;
        m_lfsr = 16'hACE1;
        m_rnd  = 16'h0000;
        tick(30);
        chk("mid_rst_quiet", q.size(), 0);

        // Run D: LFSR restarts from the reset seed.
        start = 1'b1;
        plan_run(cyc + 1);
        tick(1);
        start = 1'b0;
        wait_empty(300);
`ifdef ARCTIC_STEP_COUNT_EN
        chk("step_count_after_rst", step_count, 16'd8);
`endif

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
